rs232_tx_scheduler: RTL and testbench
=====================================

RS232_TX_SCHEDULER -- requirements
Module: rs232_tx_scheduler

Interface
REQ-001 SHALL have parameter DIV0, default 5208, meaning clocks per bit for buad_setting 2'b00 (9600 baud at 50 MHz).
REQ-002 SHALL have parameter DIV1, default 2604, meaning clocks per bit for buad_setting 2'b01 (19200 baud).
REQ-003 SHALL have parameter DIV2, default 1302, meaning clocks per bit for buad_setting 2'b10 (38400 baud).
REQ-004 SHALL have parameter DIV3, default 434, meaning clocks per bit for buad_setting 2'b11 (115200 baud).
REQ-005 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-007 SHALL have port buad_setting  input  2  baud select per REQ-001..004.
REQ-008 SHALL have port req  input  4  per-requester transmit request, level, bit i = requester i.
REQ-009 SHALL have port req_data  input  32  byte of requester i on bits [8i+7:8i].
REQ-010 SHALL have port grant  output  4  one-hot, one-cycle pulse: byte of requester i accepted.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-013 SHALL implement states IDLE, START_BIT, DATA, STOP.
REQ-014 IDLE: tx=1; if any req bit is high, on next edge SHALL select winner by round-robin, latch its byte and buad_setting-derived divisor, pulse grant[winner] for that next cycle only, enter START_BIT.
REQ-015 Round-robin: search starts at (last_winner+1) mod 4 ascending with wrap; last_winner resets to 3 so requester 0 has first priority.
REQ-016 Only the winner's grant bit SHALL pulse; other pending requests remain pending, no grant, no data loss.
REQ-017 START_BIT: tx=0 for exactly DIV clocks, then DATA.
REQ-018 DATA: 8 bits LSB first, each exactly DIV clocks, 3-bit bit index 0..7; after bit 7 enter STOP.
REQ-019 STOP: tx=1 for exactly DIV clocks, then IDLE.
REQ-020 Frame SHALL occupy 10*DIV clocks from START_BIT entry to IDLE entry; IDLE lasts at least 1 cycle between frames (min inter-frame spacing 10*DIV+1 clocks).
REQ-021 Bit timer SHALL count 0..DIV-1, reset to 0 on every state/bit change; width 13 bits minimum (DIV0 fits).
REQ-022 buad_setting and req_data changes during a frame SHALL NOT affect the frame in flight; both sampled only at the IDLE->START_BIT edge.
REQ-023 req dropped before arbitration: not served, no grant; req held after grant: treated as a new request at the next IDLE.
REQ-024 tx SHALL be driven from a register (no combinational glitches).
REQ-025 busy SHALL rise in the same cycle as grant and fall in the cycle IDLE is re-entered.

Reset
REQ-026 rst=0 SHALL immediately force: state IDLE, tx=1, busy=0, grant=4'b0000, bit timer 0, bit index 0, last_winner=3, latched byte 8'h00.
REQ-027 rst asserted mid-frame SHALL abort the frame with no grant and no resumption; after release the block arbitrates afresh from requester 0.

Verification
REQ-028 buad_setting=2'b10, req=4'b0001, req_data[7:0]=8'hA5 -> grant=4'b0001 one cycle, tx: 0 for 1302 clks, then bits 1,0,1,0,0,1,0,1 each 1302 clks, then 1 for 1302 clks; busy high 13020 clks.
REQ-029 req=4'b1111 held, distinct bytes 8'h11/22/33/44 -> grants in order 0,1,2,3,0 with matching serialized bytes; each grant one-hot.
REQ-030 After requester 2 served, req=4'b0101 -> requester 0 wins next (wrap), then 2.
REQ-031 buad_setting changed 2'b11->2'b00 mid-frame -> current frame stays 434 clks/bit; next frame 5208 clks/bit.
REQ-032 rst=0 during DATA bit 4 -> tx=1, busy=0 asynchronously; after release with req=4'b1000 -> requester 3 granted, full frame sent.
REQ-033 req pulse of 1 cycle while busy -> no grant, tx unaffected, block returns to IDLE and stays idle.

Source files
------------

// File: rtl/rs232_tx_scheduler.sv
// rs232_tx_scheduler: round-robin arbiter for four byte requesters feeding one 8N1 serial transmitter
// with a per-frame baud divisor chosen from four parameters.
module rs232_tx_scheduler #(
   parameter int DIV0 = 5208,
   parameter int DIV1 = 2604,
   parameter int DIV2 = 1302,
   parameter int DIV3 = 434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  buad_setting,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   output logic [3:0]  grant,
   output logic        busy,
   output logic        tx
);
   typedef enum logic [1:0] {IDLE, START_BIT, DATA, STOP} state_t;
   state_t      state, state_n;
   logic [12:0] tmr, tmr_n, div_q, div_n, div_sel;
   logic [2:0]  idx, idx_n;
   logic [1:0]  last_winner, lw_n, winner;
   logic [7:0]  data_q, data_n;
   logic [3:0]  grant_n;
   logic        tx_n, bit_end;
   assign busy    = state != IDLE;
   assign bit_end = tmr == div_q - 13'd1;
   assign div_sel = buad_setting == 2'd0 ? 13'(DIV0) :
                    buad_setting == 2'd1 ? 13'(DIV1) :
                    buad_setting == 2'd2 ? 13'(DIV2) : 13'(DIV3);
   // Scan from farthest to nearest so the requester right after last_winner wins.
   always_comb begin
      winner = last_winner;
      for (int i = 4; i >= 1; i--)
         if (req[last_winner + 2'(i)]) winner = last_winner + 2'(i);
   end
   always_comb begin
      state_n = state;
      tmr_n   = tmr + 13'd1;
      idx_n   = idx;
      lw_n    = last_winner;
      data_n  = data_q;
      div_n   = div_q;
      grant_n = 4'b0000;
      tx_n    = tx;
      case (state)
         IDLE: begin
            tmr_n = '0;
            tx_n  = 1'b1;
            if (|req) begin
               state_n = START_BIT;
               lw_n    = winner;
               data_n  = req_data[{winner, 3'b000} +: 8];
               div_n   = div_sel;
               grant_n = 4'b0001 << winner;
               tx_n    = 1'b0;
            end
         end
         START_BIT: if (bit_end) begin
            state_n = DATA;
            tmr_n   = '0;
            idx_n   = '0;
            tx_n    = data_q[0];
         end
         DATA: if (bit_end) begin
            tmr_n = '0;
            if (idx == 3'd7) begin
               state_n = STOP;
               tx_n    = 1'b1;
            end else begin
               idx_n = idx + 3'd1;
               tx_n  = data_q[idx + 3'd1];
            end
         end
         STOP: if (bit_end) begin
            state_n = IDLE;
            tmr_n   = '0;
            idx_n   = '0;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         tmr         <= '0;
         idx         <= '0;
         last_winner <= 2'd3;
         data_q      <= 8'h00;
         div_q       <= 13'(DIV0);
         grant       <= 4'b0000;
         tx          <= 1'b1;
      end else begin
         state       <= state_n;
         tmr         <= tmr_n;
         idx         <= idx_n;
         last_winner <= lw_n;
         data_q      <= data_n;
         div_q       <= div_n;
         grant       <= grant_n;
         tx          <= tx_n;
      end
   end
endmodule

// File: tb/tb_rs232_tx_scheduler.sv
// tb_rs232_tx_scheduler: directed checks of arbitration order, frame timing/bit order,
// baud/data latching, asynchronous reset abort and ignored short requests.
module tb_rs232_tx_scheduler;
   localparam int D0 = 20, D1 = 12, D2 = 6, D3 = 4;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  buad_setting = 2'd2;
   logic [3:0]  req = 4'b0000;
   logic [31:0] req_data = 32'h0;
   logic [3:0]  grant;
   logic        busy, tx;
   int cnt = 0, errs = 0;

   rs232_tx_scheduler #(.DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3)) dut (
      .clk(clk), .rst(rst), .buad_setting(buad_setting), .req(req),
      .req_data(req_data), .grant(grant), .busy(busy), .tx(tx));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cnt++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_grant(input logic [3:0] exp);
      int n = 0;
      while (grant == 4'b0000 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("grant", 32'(grant), 32'(exp));
      chk("busy_rise", 32'(busy), 32'd1);
   endtask

   // Called at the negedge where grant is visible (first START_BIT cycle).
   task automatic check_frame(input logic [7:0] b, input int div, input logic [3:0] pulse);
      logic [9:0] frm;
      frm = {1'b1, b, 1'b0};
      for (int c = 0; c < 10 * div; c++) begin
         if (c % div == 0 || c % div == div - 1)
            chk($sformatf("tx_bit%0d_c%0d", c / div, c), 32'(tx), 32'(frm[c / div]));
         if (c == 1) chk("grant_one_cycle", 32'(grant), 32'd0);
         if (c == 10 * div - 1) chk("busy_last", 32'(busy), 32'd1);
         if (pulse != 4'b0000 && c == 3) req = pulse;
         if (pulse != 4'b0000 && c == 4) req = 4'b0000;
         @(negedge clk);
      end
      chk("busy_fall", 32'(busy), 32'd0);
      chk("tx_idle", 32'(tx), 32'd1);
   endtask

   initial begin
      logic [3:0] seen;
      @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_no_grant", 32'(grant), 32'd0);
      // Single byte A5 at 38400 setting
      buad_setting = 2'd2; req_data = 32'h000000A5; req = 4'b0001;
      wait_grant(4'b0001);
      req = 4'b0000;
      check_frame(8'hA5, D2, 4'b0000);
      // Fresh arbitration, all requesting
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      req_data = 32'h44332211; req = 4'b1111;
      wait_grant(4'b0001); check_frame(8'h11, D2, 4'b0000);
      wait_grant(4'b0010); check_frame(8'h22, D2, 4'b0000);
      wait_grant(4'b0100); check_frame(8'h33, D2, 4'b0000);
      wait_grant(4'b1000); check_frame(8'h44, D2, 4'b0000);
      wait_grant(4'b0001);
      req = 4'b0000;
      check_frame(8'h11, D2, 4'b0000);
      // Wrap after requester 2
      req = 4'b0100;
      wait_grant(4'b0100);
      req = 4'b0101;
      check_frame(8'h33, D2, 4'b0000);
      wait_grant(4'b0001); check_frame(8'h11, D2, 4'b0000);
      wait_grant(4'b0100);
      req = 4'b0000;
      check_frame(8'h33, D2, 4'b0000);
      // Baud and data changed mid-frame only affect the next frame
      buad_setting = 2'd3; req = 4'b0010;
      wait_grant(4'b0010);
      buad_setting = 2'd0; req_data = 32'h44335A11;
      check_frame(8'h22, D3, 4'b0000);
      wait_grant(4'b0010);
      req = 4'b0000;
      check_frame(8'h5A, D0, 4'b0000);
      // Reset during data bit 4
      buad_setting = 2'd2; req_data = 32'h443322C3; req = 4'b0001;
      wait_grant(4'b0001);
      req = 4'b0000;
      repeat (5 * D2 + 2) @(negedge clk);
      chk("bit4_before_rst", 32'(tx), 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("async_tx", 32'(tx), 32'd1);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_grant", 32'(grant), 32'd0);
      req = 4'b1000;
      @(negedge clk);
      rst = 1'b1;
      wait_grant(4'b1000);
      req = 4'b0000;
      check_frame(8'h44, D2, 4'b0000);
      // Short pulse while busy is ignored
      req = 4'b0001;
      wait_grant(4'b0001);
      req = 4'b0000;
      check_frame(8'hC3, D2, 4'b0010);
      seen = 4'b0000;
      repeat (3 * D2) begin
         seen |= grant;
         @(negedge clk);
      end
      chk("pulse_no_grant", 32'(seen), 32'd0);
      chk("pulse_stay_idle", 32'(busy), 32'd0);
      chk("pulse_tx_idle", 32'(tx), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
      $finish;
   end
endmodule
